control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit CPU. It consumes the carry and zero flags latched by the ALU, together with the instruction-register opcode.
- A step counter (T0..T4) drives the combinational control word that steers bus, register, memory, ALU and PC enables.
- It is the control-side consumer of the ALU's su/fi inputs and cf/zf outputs, and implements conditional jumps.

Parameters:
- EARLY_END, 1, 1 = step counter returns to T0 after the last non-empty step; 0 = every instruction runs all five steps T0..T4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- clr_n  input  1  asynchronous active-low reset
- opcode  input  4  upper nibble of the instruction register
- cf  input  1  ALU carry flag (registered in the ALU)
- zf  input  1  ALU zero flag (registered in the ALU)
- hlt  output  1  halt the clock/sequencer
- mi  output  1  memory address register in
- ri  output  1  RAM in (write)
- ro  output  1  RAM out
- io  output  1  instruction register out (low nibble to bus)
- ii  output  1  instruction register in
- ai  output  1  A register in
- ao  output  1  A register out
- eo  output  1  ALU sum out
- su  output  1  ALU subtract
- bi  output  1  B register in
- oi  output  1  output register in
- ce  output  1  program counter enable (increment)
- co  output  1  program counter out
- j  output  1  program counter load (jump)
- fi  output  1  ALU flags in
- step  output  3  current step, 0..4 (debug)

Behaviour:
- State: 3-bit step register plus a 1-bit halted flag.
- Reset (clr_n low, asynchronous): step=0, halted=0, and every control output is forced to 0 while clr_n is low. The first clock after release executes T0.
- Control outputs are a combinational function of step, opcode, cf, zf and halted. There is no output register: a signal is valid for the whole cycle of its step.
- Fetch, identical for all opcodes:
  - T0 = co|mi
  - T1 = ro|ii|ce
  - The IR loads on the T1 edge, so opcode is valid from T2 onward.
- Execute words (steps not listed are empty):
  - 0 NOP: none
  - 1 LDA: T2 io|mi; T3 ro|ai
  - 2 ADD: T2 io|mi; T3 ro|bi; T4 eo|ai|fi
  - 3 SUB: T2 io|mi; T3 ro|bi; T4 eo|ai|su|fi
  - 4 STA: T2 io|mi; T3 ao|ri
  - 5 LDI: T2 io|ai
  - 6 JMP: T2 io|j
  - 7 JC: T2 io|j if cf=1, else empty
  - 8 JZ: T2 io|j if zf=1, else empty
  - E OUT: T2 ao|oi
  - F HLT: T2 hlt
  - 9..D: treated as NOP
- Step advance:
  - T0→T1→T2 unconditionally.
  - From step n≥2: next = 0 if n==4, or if EARLY_END=1 and the word for step n+1 (current opcode/flags) is empty; otherwise next = n+1.
  - Cycle counts with EARLY_END=1: NOP/LDI/JMP/OUT/not-taken jumps 3; LDA/STA 4; ADD/SUB 5.
  - With EARLY_END=0 every instruction takes 5 cycles.
- Flags are sampled combinationally in T2 only. fi fires only in T4, the final step, so flags never change mid-decision.
- HLT:
  - T2 drives hlt=1; at that edge halted<=1.
  - While halted: hlt=1, all other outputs 0, step frozen at 2.
  - Only clr_n exits halt.
- Reset asserted mid-instruction: outputs drop to 0 immediately and the next instruction starts at T0 after release. No partial completion.
- opcode changes outside T1/T2 have no effect on the step sequence except through the word of the current step.

Test Plan:
- Reset release, opcode=1 (LDA): step sequence 0,1,2,3,0. Control words in order are co|mi, ro|ii|ce, io|mi, ro|ai. All outputs 0 during reset.
- opcode=3 (SUB): 5 cycles. T4 asserts eo|ai|su|fi together; no other step asserts su or fi.
- opcode=7 (JC):
  - cf=1: T2 asserts io|j, step returns to 0 after 3 cycles.
  - cf=0: T2 word is all 0, j never asserts, still 3 cycles.
  - Repeat with opcode=8 using zf.
- EARLY_END=0, opcode=5 (LDI): step runs 0..4 (5 cycles). T3 and T4 are all-zero words.
- opcode=F (HLT): hlt=1 from T2 onward, step holds 2 for 10+ cycles with all other outputs 0. Pulsing clr_n low clears hlt and step=0.
- Assert clr_n low during T3 of ADD: bi drops to 0 asynchronously. After release, step=0 and co|mi are asserted; no eo/fi pulse occurs.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: a T0..T4 step counter and a
// combinational control word decoded from step, opcode and the ALU flags.
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] opcode,
    input  logic       cf,
    input  logic       zf,
    output logic       hlt,
    output logic       mi,
    output logic       ri,
    output logic       ro,
    output logic       io,
    output logic       ii,
    output logic       ai,
    output logic       ao,
    output logic       eo,
    output logic       su,
    output logic       bi,
    output logic       oi,
    output logic       ce,
    output logic       co,
    output logic       j,
    output logic       fi,
    output logic [2:0] step
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    typedef struct packed {
        logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
    } ctrl_t;

    // Steps outside T0..T4 decode to an empty word, which lets the lookahead
    // past T4 fall out naturally.
    function automatic ctrl_t decode(input step_t s, input logic [3:0] op,
                                     input logic c, input logic z);
        ctrl_t w;
        w = '0;
        case (s)
            T0: begin w.co = 1'b1; w.mi = 1'b1; end
            T1: begin w.ro = 1'b1; w.ii = 1'b1; w.ce = 1'b1; end
            T2: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4: begin w.io = 1'b1; w.mi = 1'b1; end
                    4'h5: begin w.io = 1'b1; w.ai = 1'b1; end
                    4'h6: begin w.io = 1'b1; w.j = 1'b1; end
                    4'h7: begin w.io = c; w.j = c; end
                    4'h8: begin w.io = z; w.j = z; end
                    4'hE: begin w.ao = 1'b1; w.oi = 1'b1; end
                    4'hF: w.hlt = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (op)
                    4'h1: begin w.ro = 1'b1; w.ai = 1'b1; end
                    4'h2, 4'h3: begin w.ro = 1'b1; w.bi = 1'b1; end
                    4'h4: begin w.ao = 1'b1; w.ri = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                if (op == 4'h2 || op == 4'h3) begin
                    w.eo = 1'b1; w.ai = 1'b1; w.fi = 1'b1; w.su = (op == 4'h3);
                end
            end
            default: ;
        endcase
        return w;
    endfunction

    step_t step_q, step_d;
    logic  halted, halted_d;
    ctrl_t word, next_word, ctrl;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step_q <= T0;
            halted <= 1'b0;
        end else begin
            step_q <= step_d;
            halted <= halted_d;
        end
    end

    always_comb begin
        word      = decode(step_q, opcode, cf, zf);
        next_word = decode(step_t'(step_q + 3'd1), opcode, cf, zf);
        step_d    = step_q;
        halted_d  = halted;
        ctrl      = '0;
        if (halted) begin
            ctrl.hlt = 1'b1;
        end else begin
            ctrl = word;
            case (step_q)
                T0: step_d = T1;
                T1: step_d = T2;
                default: begin
                    // HLT keeps the step parked at T2 until reset
                    if (word.hlt)
                        halted_d = 1'b1;
                    else if (step_q == T4 || (EARLY_END && next_word == '0))
                        step_d = T0;
                    else
                        step_d = step_t'(step_q + 3'd1);
                end
            endcase
        end
        if (!clr_n)
            ctrl = '0;
    end

    assign hlt  = ctrl.hlt;
    assign mi   = ctrl.mi;
    assign ri   = ctrl.ri;
    assign ro   = ctrl.ro;
    assign io   = ctrl.io;
    assign ii   = ctrl.ii;
    assign ai   = ctrl.ai;
    assign ao   = ctrl.ao;
    assign eo   = ctrl.eo;
    assign su   = ctrl.su;
    assign bi   = ctrl.bi;
    assign oi   = ctrl.oi;
    assign ce   = ctrl.ce;
    assign co   = ctrl.co;
    assign j    = ctrl.j;
    assign fi   = ctrl.fi;
    assign step = step_q;

endmodule
